// File: rtl/multicycle_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_adder_if
// Description : Handshake and data bundle for multicycle_adder.
//               The operand side (valid_in/ready_in, a, b, c_in) and the
//               result side (valid_out/ready_out, res, c_out, overflow)
//               travel together.
//               master : producer/consumer that surrounds the adder
//               slave  : the adder itself
// Revision    : 1.0  initial release
// ============================================================================
interface multicycle_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             valid_out;
    logic             ready_out;
    logic [WIDTH-1:0] res;
    logic             c_out;
    logic             overflow;

    modport master (
        output valid_in, a, b, c_in, ready_out,
        input  ready_in, valid_out, res, c_out, overflow
    );

    modport slave (
        input  valid_in, a, b, c_in, ready_out,
        output ready_in, valid_out, res, c_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_adder
// Description : Chunk-serial adder. Adds two WIDTH-bit operands plus carry-in
//               CHUNK bits per clock using one CHUNK-wide adder slice, over
//               N = WIDTH/CHUNK cycles. Reports carry-out and signed overflow.
// Ports       : clk    - sole clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - multicycle_adder_if.slave: valid_in/ready_in, a, b,
//                        c_in, valid_out/ready_out, res, c_out, overflow
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  wire                 clk,
    input  wire                 rst_n,
    multicycle_adder_if.slave   bus
);
    localparam int N   = WIDTH / CHUNK;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;

    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_c_out;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign w_last = (r_cnt == c_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.valid_in)  w_state_next = c_CALC;
            c_CALC:  if (w_last)        w_state_next = c_DONE;
            c_DONE:  if (bus.ready_out) w_state_next = c_IDLE;
            default:                    w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake outputs, decoded from state only
    // ------------------------------------------------------------------
    always_comb begin
        bus.ready_in  = (r_state == c_IDLE);
        bus.valid_out = (r_state == c_DONE);
    end

    // ------------------------------------------------------------------
    // Chunk select and adder slice. The mux is written as a constant-index
    // loop so every part-select has a fixed base.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_slice = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

    // Sum with the current chunk already merged, so the final edge can load
    // res directly without waiting a cycle for r_sum.
    always_comb begin
        w_sum_next = r_sum;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CW'(i)) begin
                w_sum_next[i*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.valid_in) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.c_in;
                        r_cnt   <= '0;
                    end
                end
                c_CALC: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice[CHUNK];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res   <= w_sum_next;
                        r_c_out <= w_slice[CHUNK];
                        r_ovf   <= (r_a[MSB] == r_b[MSB]) && (w_sum_next[MSB] != r_a[MSB]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.res      = r_res;
    assign bus.c_out    = r_c_out;
    assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_adder
// Description : Self-checking bench for multicycle_adder. A transaction-level
//               model predicts handshake and result outputs for the
//               WIDTH=8/CHUNK=2 instance every cycle; directed literal checks
//               pin the model and cover the WIDTH=8/CHUNK=8 instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_adder;
    localparam int N0 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multicycle_adder_if #(.WIDTH(8)) bus0 ();
    multicycle_adder_if #(.WIDTH(8)) bus1 ();

    multicycle_adder #(.WIDTH(8), .CHUNK(2)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: a result is a+b+c_in; it appears N0 edges after
    // acceptance and stays until the consumer takes it.
    // phase 0 = waiting for operands, 1 = busy, 2 = result offered
    // ------------------------------------------------------------------
    int         m_phase = 0;
    int         m_left  = 0;
    logic [7:0] m_res   = 8'h00;
    logic       m_c     = 1'b0;
    logic       m_o     = 1'b0;
    logic [7:0] p_res;
    logic       p_c;
    logic       p_o;
    logic [8:0] sum9;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_res   = 8'h00;
            m_c     = 1'b0;
            m_o     = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus0.valid_in === 1'b1) begin
                    sum9    = {1'b0, bus0.a} + {1'b0, bus0.b} + {8'h00, bus0.c_in};
                    p_res   = sum9[7:0];
                    p_c     = sum9[8];
                    p_o     = (bus0.a[7] == bus0.b[7]) && (sum9[7] != bus0.a[7]);
                    m_left  = N0;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_res   = p_res;
                        m_c     = p_c;
                        m_o     = p_o;
                    end
                end
                default: if (bus0.ready_out === 1'b1) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model ready_in",  {31'b0, bus0.ready_in},  {31'b0, m_phase == 0});
            check("model valid_out", {31'b0, bus0.valid_out}, {31'b0, m_phase == 2});
            check("model res",       {24'b0, bus0.res},       {24'b0, m_res});
            check("model c_out",     {31'b0, bus0.c_out},     {31'b0, m_c});
            check("model overflow",  {31'b0, bus0.overflow},  {31'b0, m_o});
        end
    end

    // ------------------------------------------------------------------
    // Directed operation on the N=4 instance, entered at a negedge while idle
    // ------------------------------------------------------------------
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] er, input logic ec, input logic eo,
                          input bit scramble, input int hold);
        int lat;
        bus0.valid_in = 1'b1;
        bus0.a        = a;
        bus0.b        = b;
        bus0.c_in     = ci;
        @(negedge clk);
        bus0.valid_in = 1'b0;
        check("ready_in low after accept", {31'b0, bus0.ready_in}, 32'd0);
        if (scramble) begin
            bus0.a    = 8'hFF;
            bus0.b    = 8'hFF;
            bus0.c_in = 1'b1;
        end
        lat = 0;
        while (bus0.valid_out !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, N0);
        check("res",      {24'b0, bus0.res},      {24'b0, er});
        check("c_out",    {31'b0, bus0.c_out},    {31'b0, ec});
        check("overflow", {31'b0, bus0.overflow}, {31'b0, eo});
        for (int k = 0; k < hold; k++) begin
            bus0.valid_in = (k == 1);
            bus0.a        = 8'h11;
            @(negedge clk);
            check("hold valid_out", {31'b0, bus0.valid_out}, 32'd1);
            check("hold ready_in",  {31'b0, bus0.ready_in},  32'd0);
            check("hold res",       {24'b0, bus0.res},       {24'b0, er});
        end
        bus0.valid_in  = 1'b0;
        bus0.ready_out = 1'b1;
        @(negedge clk);
        bus0.ready_out = 1'b0;
        check("back to idle", {31'b0, bus0.ready_in}, 32'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] r;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[4] = '{
        '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
        '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0, 1'b0},
        '{8'hC3, 8'h3D, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1}
    };

    initial begin
        int lat;
        bus0.valid_in = 1'b0; bus0.ready_out = 1'b0;
        bus0.a = 8'h00; bus0.b = 8'h00; bus0.c_in = 1'b0;
        bus1.valid_in = 1'b0; bus1.ready_out = 1'b0;
        bus1.a = 8'h00; bus1.b = 8'h00; bus1.c_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state on both instances
        check("rst ready_in",  {31'b0, bus0.ready_in},  32'd1);
        check("rst valid_out", {31'b0, bus0.valid_out}, 32'd0);
        check("rst res",       {24'b0, bus0.res},       32'd0);
        check("rst c_out",     {31'b0, bus0.c_out},     32'd0);
        check("rst overflow",  {31'b0, bus0.overflow},  32'd0);
        check("rst1 ready_in", {31'b0, bus1.ready_in},  32'd1);
        check("rst1 res",      {24'b0, bus1.res},       32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1..3: basic sum, full ripple, carry-in with overflow
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 0);

        // 4: operands changed during CALC, then 3 cycles of backpressure
        run_op(8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0, 1'b1, 3);

        // Additional directed vectors
        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].r, vecs[i].c, vecs[i].o, 1'b0, 0);

        // 5: reset on the 2nd CALC edge discards the operation
        bus0.valid_in = 1'b1; bus0.a = 8'h12; bus0.b = 8'h34; bus0.c_in = 1'b0;
        @(negedge clk);
        bus0.valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst ready_in",  {31'b0, bus0.ready_in},  32'd1);
        check("midrst valid_out", {31'b0, bus0.valid_out}, 32'd0);
        check("midrst res",       {24'b0, bus0.res},       32'd0);
        check("midrst c_out",     {31'b0, bus0.c_out},     32'd0);
        check("midrst overflow",  {31'b0, bus0.overflow},  32'd0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 0);

        // 6: single-chunk instance
        bus1.valid_in = 1'b1; bus1.a = 8'h7F; bus1.b = 8'h01; bus1.c_in = 1'b0;
        @(negedge clk);
        bus1.valid_in = 1'b0;
        check("n1 ready_in after accept", {31'b0, bus1.ready_in}, 32'd0);
        lat = 0;
        while (bus1.valid_out !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("n1 latency",  lat, 1);
        check("n1 res",      {24'b0, bus1.res},      32'h80);
        check("n1 c_out",    {31'b0, bus1.c_out},    32'd0);
        check("n1 overflow", {31'b0, bus1.overflow}, 32'd1);
        bus1.ready_out = 1'b1;
        @(negedge clk);
        bus1.ready_out = 1'b0;
        check("n1 back to idle", {31'b0, bus1.ready_in}, 32'd1);
        check("n1 res held",     {24'b0, bus1.res},      32'h80);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
